// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with one-hot plus binary grant, held until release.
// Optional hold-time watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] owner;

    // Legal MAX_HOLD range is 2..255; the hold counter is 8 bits wide.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_out_of_range
    end

    // First requester at or after ptr, wrapping modulo 8.
    logic       found;
    logic [2:0] winner;
    logic [2:0] cand;

    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = ptr;
        for (int k = 0; k < 8; k++) begin
            cand = ptr + 3'(k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            owner     <= 3'd0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold      <= 8'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= winner;
                        gnt       <= 8'h01 << winner;
                        gnt_idx   <= winner;
                        gnt_valid <= 1'b1;
                        hold      <= 8'd0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // A release in the final allowed cycle wins over the watchdog.
                    if (!req[owner] || hold == HOLD_LAST) begin
                        gnt       <= 8'h00;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        ptr       <= owner + 3'd1;
                        timeout   <= req[owner];
                        state     <= IDLE;
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign timeout = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            owner     <= 3'd0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= winner;
                        gnt       <= 8'h01 << winner;
                        gnt_idx   <= winner;
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[owner]) begin
                        gnt       <= 8'h00;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        ptr       <= owner + 3'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus random traffic against a turn-based model.
// Build with ARB_TIMEOUT_EN defined to also exercise the hold-time watchdog (MAX_HOLD=4).
module tb_rr_arbiter_8;

    localparam int TB_MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter_8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: who holds the resource, whose turn is first, how long it has held
    int          m_owner = -1;  // -1 while nobody holds the resource
    int          m_first = 0;   // requester with highest priority in the next contest
    int          m_held  = 0;   // cycles the current owner has held the grant
    bit          m_to    = 1'b0;
    logic [12:0] exp_q[$];

    always @(posedge clk) begin
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_first = 0;
            m_held  = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_first = (m_owner + 1) % 8;
                m_owner = -1;
            end else if (TO_EN && m_held == TB_MAX_HOLD) begin
                m_first = (m_owner + 1) % 8;
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held = m_held + 1;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && req[(m_first + k) % 8]) m_owner = (m_first + k) % 8;
            end
            if (m_owner >= 0) m_held = 1;
        end
        if (m_owner >= 0)
            exp_q.push_back({8'(1 << m_owner), 3'(m_owner), 1'b1, m_to});
        else
            exp_q.push_back({8'h00, 3'd0, 1'b0, m_to});
    end

    // scoreboard
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver: advance one cycle and compare the registered outputs with the model
    task automatic tick(input string tag);
        logic [12:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {19'd0, gnt, gnt_idx, gnt_valid, timeout}, {19'd0, e});
        end
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        // reset, then idle
        rst = 1'b1;
        req = 8'h00;
        ticks("reset", 2);
        rst = 1'b0;
        ticks("idle", 5);

        // two simultaneous requesters, ptr order then wrap
        req = 8'h81;
        ticks("pair_grant0", 3);
        req = 8'h80;
        ticks("pair_grant7", 4);
        req = 8'h00;
        ticks("pair_release7", 2);
        req = 8'h81;
        ticks("pair_wrap", 2);
        req = 8'h00;
        ticks("pair_drain", 2);

        // all requesting, each owner keeps it 3 cycles then re-raises after the bubble
        req = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            tick("rotate");
            if (m_owner >= 0 && m_held == 3) req = 8'hFF & ~8'(1 << m_owner);
            else req = 8'hFF;
        end
        req = 8'h00;
        ticks("rotate_drain", 3);

        // non-owner bits toggling while 2 holds the grant
        req = 8'h04;
        ticks("toggle_enter", 2);
        for (int i = 0; i < 6; i++) begin
            req[5] = ~req[5];
            req[6] = $urandom_range(0, 1) == 1;
            tick("toggle_hold");
        end
        req[2] = 1'b0;
        ticks("toggle_next", 4);
        req = 8'h00;
        ticks("toggle_drain", 3);

        // single requester held far beyond MAX_HOLD
        req = 8'h08;
        ticks("hold_long", 14);
        req = 8'h00;
        ticks("hold_drain", 3);

        // reset during a grant to 4, then ptr is back at 0
        req = 8'h10;
        ticks("rst_enter", 3);
        rst = 1'b1;
        tick("rst_mid_grant");
        rst = 1'b0;
        req = 8'h11;
        ticks("rst_after", 3);
        req = 8'h00;
        ticks("rst_drain", 3);

        // random traffic: owners release at random, others raise and drop freely
        for (int c = 0; c < 3000; c++) begin
            tick("random");
            for (int i = 0; i < 8; i++) begin
                if (m_owner == i) begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end
            end
            rst = $urandom_range(0, 199) == 0;
        end
        rst = 1'b0;
        req = 8'h00;
        ticks("final_drain", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
